// File: rtl/sc_backg_sequencer_pkg.sv
// Shared definitions for the background-type register sequencer:
// state encodings, scroll and level codes, and the inactive control bus.
package sc_backg_sequencer_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_LOSE_P = 3'd4,
    ST_LOSE_H = 3'd5,
    ST_WIN_P  = 3'd6,
    ST_WIN_H  = 3'd7
  } state_t;

  // Scroll codes understood by the register rows
  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Level codes; NIVEL_NONE means "no level pattern load this cycle"
  localparam logic [1:0] NIVEL_NONE = 2'b00;
  localparam logic [1:0] LEVEL_1    = 2'b01;
  localparam logic [1:0] LEVEL_2    = 2'b10;
  localparam logic [1:0] LEVEL_3    = 2'b11;

  // Control bus shared by every background register row
  typedef struct packed {
    logic       clearLow;
    logic [1:0] shiftSel;
    logic       crashLow;
    logic       cleanLow;
    logic [1:0] nivel;
  } ctrl_t;

  localparam ctrl_t CTRL_INACTIVE = '{
    clearLow: 1'b1,
    shiftSel: SHIFT_NONE,
    crashLow: 1'b1,
    cleanLow: 1'b1,
    nivel:    NIVEL_NONE
  };

endpackage

// File: rtl/sc_backg_sequencer_tick.sv
// Period counter: counts 0..period-1 and flags the last count as a tick.
// Held at zero while clear is high so the first tick after release comes
// exactly one period later.
module sc_backgseq_tick
  import sc_backg_sequencer_pkg::*;
(
  input  logic             SC_TICK_CLOCK_50,
  input  logic             SC_TICK_RESET_InLow,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] countReg;

  // Tick on the last count of the period; comparing against period-1 gives
  // exactly one tick every period cycles.
  always_comb begin
    tick = (countReg == (period - {{(CNT_W-1){1'b0}}, 1'b1}));
  end

  // Counter register: zeroed on reset or clear, wraps after the tick
  always_ff @(posedge SC_TICK_CLOCK_50) begin
    if (!SC_TICK_RESET_InLow || clear) begin
      countReg <= '0;
    end else if (tick) begin
      countReg <= '0;
    end else begin
      countReg <= countReg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sc_backg_sequencer.sv
// Sequencer for the background-type register bank. Converts start, crash
// and win events into ordered one-cycle control pulses and a periodic
// scroll. All outputs are decoded from registered state, level and counter.
module sc_backg_sequencer
  import sc_backg_sequencer_pkg::*;
#(
  parameter logic [CNT_W-1:0] SHIFT_PERIOD_L1 = 24'd5000000,
  parameter logic [CNT_W-1:0] SHIFT_PERIOD_L2 = 24'd2500000,
  parameter logic [CNT_W-1:0] SHIFT_PERIOD_L3 = 24'd1250000,
  parameter logic [1:0]       SHIFTDIR_L1     = 2'b01,
  parameter logic [1:0]       SHIFTDIR_L2     = 2'b10,
  parameter logic [1:0]       SHIFTDIR_L3     = 2'b01
) (
  input  logic       SC_BACKGSEQ_CLOCK_50,
  input  logic       SC_BACKGSEQ_RESET_InLow,
  input  logic       SC_BACKGSEQ_start_InLow,
  input  logic       SC_BACKGSEQ_crash_InLow,
  input  logic       SC_BACKGSEQ_win_InLow,
  output logic       SC_BACKGSEQ_clear_OutLow,
  output logic [1:0] SC_BACKGSEQ_shiftselection_Out,
  output logic       SC_BACKGSEQ_crash_OutLow,
  output logic       SC_BACKGSEQ_clean_OutLow,
  output logic [1:0] SC_BACKGSEQ_nivel_Out,
  output logic [1:0] SC_BACKGSEQ_level_Out,
  output logic       SC_BACKGSEQ_running_OutHigh,
  output logic [2:0] SC_BACKGSEQ_state_Out
);

  state_t           stateReg;
  state_t           stateNext;
  logic [1:0]       levelReg;
  logic [CNT_W-1:0] periodSel;
  logic [1:0]       dirSel;
  logic             tickPulse;
  ctrl_t            ctrl;

  // Scroll period and direction for the current level
  always_comb begin
    periodSel = SHIFT_PERIOD_L1;
    dirSel    = SHIFTDIR_L1;
    case (levelReg)
      LEVEL_2: begin
        periodSel = SHIFT_PERIOD_L2;
        dirSel    = SHIFTDIR_L2;
      end
      LEVEL_3: begin
        periodSel = SHIFT_PERIOD_L3;
        dirSel    = SHIFTDIR_L3;
      end
      default: begin
        periodSel = SHIFT_PERIOD_L1;
        dirSel    = SHIFTDIR_L1;
      end
    endcase
  end

  // Counter only runs in RUN; any other state parks it at zero
  sc_backgseq_tick u_tick (
    .SC_TICK_CLOCK_50    (SC_BACKGSEQ_CLOCK_50),
    .SC_TICK_RESET_InLow (SC_BACKGSEQ_RESET_InLow),
    .clear               (stateReg != ST_RUN),
    .period              (periodSel),
    .tick                (tickPulse)
  );

  // State register
  always_ff @(posedge SC_BACKGSEQ_CLOCK_50) begin
    if (!SC_BACKGSEQ_RESET_InLow) begin
      stateReg <= ST_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic; crash has priority over win, events ignored outside
  // the states that listen for them
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:   if (!SC_BACKGSEQ_start_InLow) stateNext = ST_CLEAR;
      ST_CLEAR:  stateNext = ST_LOAD;
      ST_LOAD:   stateNext = ST_RUN;
      ST_RUN: begin
        if (!SC_BACKGSEQ_crash_InLow) begin
          stateNext = ST_LOSE_P;
        end else if (!SC_BACKGSEQ_win_InLow) begin
          stateNext = (levelReg == LEVEL_3) ? ST_WIN_P : ST_LOAD;
        end
      end
      ST_LOSE_P: stateNext = ST_LOSE_H;
      ST_WIN_P:  stateNext = ST_WIN_H;
      ST_LOSE_H: if (!SC_BACKGSEQ_start_InLow) stateNext = ST_CLEAR;
      ST_WIN_H:  if (!SC_BACKGSEQ_start_InLow) stateNext = ST_CLEAR;
      default:   stateNext = ST_IDLE;
    endcase
  end

  // Level register: back to 1 on entering CLEAR, +1 on a mid-game win
  always_ff @(posedge SC_BACKGSEQ_CLOCK_50) begin
    if (!SC_BACKGSEQ_RESET_InLow) begin
      levelReg <= LEVEL_1;
    end else if (stateNext == ST_CLEAR) begin
      levelReg <= LEVEL_1;
    end else if ((stateReg == ST_RUN) && (stateNext == ST_LOAD)) begin
      levelReg <= levelReg + 2'd1;
    end
  end

  // Output decode: at most one control active, each for a single cycle
  always_comb begin
    ctrl = CTRL_INACTIVE;
    case (stateReg)
      ST_CLEAR:  ctrl.clearLow = 1'b0;
      ST_LOAD:   ctrl.nivel    = levelReg;
      ST_RUN:    if (tickPulse) ctrl.shiftSel = dirSel;
      ST_LOSE_P: ctrl.crashLow = 1'b0;
      ST_WIN_P:  ctrl.cleanLow = 1'b0;
      default:   ctrl = CTRL_INACTIVE;
    endcase
  end

  assign SC_BACKGSEQ_clear_OutLow       = ctrl.clearLow;
  assign SC_BACKGSEQ_shiftselection_Out = ctrl.shiftSel;
  assign SC_BACKGSEQ_crash_OutLow       = ctrl.crashLow;
  assign SC_BACKGSEQ_clean_OutLow       = ctrl.cleanLow;
  assign SC_BACKGSEQ_nivel_Out          = ctrl.nivel;
  assign SC_BACKGSEQ_level_Out          = levelReg;
  assign SC_BACKGSEQ_running_OutHigh    = (stateReg == ST_RUN);
  assign SC_BACKGSEQ_state_Out          = stateReg;

endmodule

// File: tb/tb_sc_backg_sequencer.sv
// Directed bench for sc_backg_sequencer with short scroll periods.
module tb_sc_backg_sequencer;

  logic       clk = 1'b0;
  logic       rstLow = 1'b0;
  logic       startLow = 1'b1;
  logic       crashLow = 1'b1;
  logic       winLow = 1'b1;
  logic       clearOut;
  logic [1:0] shiftOut;
  logic       crashOut;
  logic       cleanOut;
  logic [1:0] nivelOut;
  logic [1:0] levelOut;
  logic       runOut;
  logic [2:0] stateOut;

  int testsRun = 0;
  int testsFailed = 0;

  // Hand-written state encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_LOSE_P = 3'd4;
  localparam logic [2:0] S_LOSE_H = 3'd5;
  localparam logic [2:0] S_WIN_P  = 3'd6;
  localparam logic [2:0] S_WIN_H  = 3'd7;

  sc_backg_sequencer #(
    .SHIFT_PERIOD_L1(24'd4),
    .SHIFT_PERIOD_L2(24'd6),
    .SHIFT_PERIOD_L3(24'd5)
  ) dut (
    .SC_BACKGSEQ_CLOCK_50           (clk),
    .SC_BACKGSEQ_RESET_InLow        (rstLow),
    .SC_BACKGSEQ_start_InLow        (startLow),
    .SC_BACKGSEQ_crash_InLow        (crashLow),
    .SC_BACKGSEQ_win_InLow          (winLow),
    .SC_BACKGSEQ_clear_OutLow       (clearOut),
    .SC_BACKGSEQ_shiftselection_Out (shiftOut),
    .SC_BACKGSEQ_crash_OutLow       (crashOut),
    .SC_BACKGSEQ_clean_OutLow       (cleanOut),
    .SC_BACKGSEQ_nivel_Out          (nivelOut),
    .SC_BACKGSEQ_level_Out          (levelOut),
    .SC_BACKGSEQ_running_OutHigh    (runOut),
    .SC_BACKGSEQ_state_Out          (stateOut)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle just past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input string field,
                          input logic [2:0] got, input logic [2:0] want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("FAIL %s.%s got %0b want %0b", tag, field, got, want);
    end
  endtask

  task automatic chk(input string tag, input logic clr, input logic [1:0] sh,
                     input logic cr, input logic cl, input logic [1:0] nv,
                     input logic [1:0] lv, input logic run, input logic [2:0] st);
    checkVal(tag, "clear", {2'b00, clearOut}, {2'b00, clr});
    checkVal(tag, "shift", {1'b0, shiftOut}, {1'b0, sh});
    checkVal(tag, "crash", {2'b00, crashOut}, {2'b00, cr});
    checkVal(tag, "clean", {2'b00, cleanOut}, {2'b00, cl});
    checkVal(tag, "nivel", {1'b0, nivelOut}, {1'b0, nv});
    checkVal(tag, "level", {1'b0, levelOut}, {1'b0, lv});
    checkVal(tag, "running", {2'b00, runOut}, {2'b00, run});
    checkVal(tag, "state", stateOut, st);
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    chk("reset", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_IDLE);

    // Released, no start: stays idle
    rstLow = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_IDLE);
    end

    // Start pulse in cycle 0
    startLow = 1'b0;
    cyc();
    startLow = 1'b1;
    chk("c1_clear", 0, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_CLEAR);
    cyc();
    chk("c2_load", 1, 2'b00, 1, 1, 2'b01, 2'b01, 0, S_LOAD);
    for (int c = 3; c <= 15; c++) begin
      cyc();
      chk("l1_run", 1, (c == 6 || c == 10 || c == 14) ? 2'b01 : 2'b00,
          1, 1, 2'b00, 2'b01, 1, S_RUN);
    end

    // Win at level 1 -> level 2 load next cycle
    winLow = 1'b0;
    cyc();
    winLow = 1'b1;
    chk("c16_load2", 1, 2'b00, 1, 1, 2'b10, 2'b10, 0, S_LOAD);
    for (int c = 17; c <= 29; c++) begin
      cyc();
      chk("l2_run", 1, (c == 22 || c == 28) ? 2'b10 : 2'b00,
          1, 1, 2'b00, 2'b10, 1, S_RUN);
    end

    // Win at level 2 -> level 3
    winLow = 1'b0;
    cyc();
    winLow = 1'b1;
    chk("c30_load3", 1, 2'b00, 1, 1, 2'b11, 2'b11, 0, S_LOAD);
    for (int c = 31; c <= 36; c++) begin
      cyc();
      chk("l3_run", 1, (c == 35) ? 2'b01 : 2'b00, 1, 1, 2'b00, 2'b11, 1, S_RUN);
    end

    // Win at level 3 -> clean pulse then hold
    winLow = 1'b0;
    cyc();
    winLow = 1'b1;
    chk("win_p", 1, 2'b00, 1, 0, 2'b00, 2'b11, 0, S_WIN_P);
    cyc();
    chk("win_h", 1, 2'b00, 1, 1, 2'b00, 2'b11, 0, S_WIN_H);
    crashLow = 1'b0;
    winLow = 1'b0;
    cyc();
    crashLow = 1'b1;
    winLow = 1'b1;
    chk("win_h_ign", 1, 2'b00, 1, 1, 2'b00, 2'b11, 0, S_WIN_H);
    cyc();
    chk("win_h_hold", 1, 2'b00, 1, 1, 2'b00, 2'b11, 0, S_WIN_H);

    // Restart from WIN_H
    startLow = 1'b0;
    cyc();
    startLow = 1'b1;
    chk("re_clear", 0, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_CLEAR);
    cyc();
    chk("re_load", 1, 2'b00, 1, 1, 2'b01, 2'b01, 0, S_LOAD);
    for (int r = 0; r < 3; r++) begin
      cyc();
      chk("re_run", 1, 2'b00, 1, 1, 2'b00, 2'b01, 1, S_RUN);
    end

    // Crash and win together on a scroll cycle: scroll still issued
    cyc();
    crashLow = 1'b0;
    winLow = 1'b0;
    #1;
    chk("cw_scroll", 1, 2'b01, 1, 1, 2'b00, 2'b01, 1, S_RUN);
    cyc();
    crashLow = 1'b1;
    winLow = 1'b1;
    chk("lose_p", 1, 2'b00, 0, 1, 2'b00, 2'b01, 0, S_LOSE_P);
    cyc();
    chk("lose_h", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_LOSE_H);
    winLow = 1'b0;
    crashLow = 1'b0;
    cyc();
    winLow = 1'b1;
    crashLow = 1'b1;
    chk("lose_h_ign", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_LOSE_H);
    cyc();
    chk("lose_h_hold", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_LOSE_H);

    // Restart, then reset two cycles into RUN
    startLow = 1'b0;
    cyc();
    startLow = 1'b1;
    chk("r2_clear", 0, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_CLEAR);
    cyc();
    chk("r2_load", 1, 2'b00, 1, 1, 2'b01, 2'b01, 0, S_LOAD);
    cyc();
    cyc();
    chk("r2_run", 1, 2'b00, 1, 1, 2'b00, 2'b01, 1, S_RUN);
    rstLow = 1'b0;
    cyc();
    rstLow = 1'b1;
    chk("mid_reset", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_IDLE);

    // Crash/win before a new start produce nothing
    crashLow = 1'b0;
    winLow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_ign", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_IDLE);
    end
    crashLow = 1'b1;
    winLow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("idle_end", 1, 2'b00, 1, 1, 2'b00, 2'b01, 0, S_IDLE);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
